uart_mmio_slave: RTL and testbench
==================================

// Module: uart_mmio_slave
// PURPOSE
//  Memory-mapped UART responder serving CPU loads/stores at UART_BASE 0x1001_3000.
//  Register map: DATA @0x0, STATUS @0x4, CTRL @0x8.
//  Contains a TX serialiser, an RX deserialiser with input synchroniser, and an RX FIFO.
//  Sits between the core's data bus and the board uart pins; boot firmware polls STATUS and echoes via DATA.
// PARAMETERS
//  CLK_DIV      868  clk cycles per UART bit (100 MHz / 115200); legal >= 4
//  RX_FIFO_DEPTH 4   RX FIFO entries, power of two, >= 2
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-high
//  bus_valid  in   1   request strobe; held by master until bus_ready
//  bus_we     in   1   1=store, 0=load
//  bus_addr   in   4   byte offset; only [3:2] decoded
//  bus_wdata  in   32  store data
//  bus_rdata  out  32  load data, valid while bus_ready=1
//  bus_ready  out  1   one-cycle completion pulse
//  uart_rxd   in   1   serial input, asynchronous
//  uart_txd   out  1   serial output, idles high
// BEHAVIOUR
//  Reset: bus_ready=0, bus_rdata=0, uart_txd=1, CTRL.en=0, FIFO empty, all flags 0, both FSMs IDLE.
//  Bus handshake:
//   - Request accepted on a cycle with bus_valid=1 and bus_ready=0.
//   - bus_ready=1 for exactly the next cycle, with bus_rdata registered (0 for stores).
//   - Side effects (pop/push/reg write) take place in the accept cycle.
//   - Minimum 2 cycles per access.
//  DATA read:
//   - Returns {24'b0, fifo_head} and pops the head.
//   - FIFO empty: returns 0, no pop.
//  DATA write:
//   - If en=1 and tx_ready=1: latch wdata[7:0] and start a frame.
//   - Otherwise the write is dropped silently.
//  STATUS read = {27'b0, frame_err, overrun, rx_valid, tx_ready, tx_busy}.
//   - rx_valid = FIFO not empty.
//   - tx_ready = en & TX IDLE.
//   - tx_busy = TX not IDLE.
//  STATUS write: wdata[3]=1 clears overrun; wdata[4]=1 clears frame_err. Other bits are ignored.
//  CTRL: bit0 en, read/write; bits [31:1] read 0.
//  Offset 0xC: read returns 0; write ignored.
//  TX FSM, states IDLE -> START -> DATA(8) -> STOP -> IDLE:
//   - Each bit lasts CLK_DIV cycles.
//   - Start bit is 0; data goes LSB first; stop bit is 1.
//   - uart_txd changes on the cycle after the write is accepted.
//   - tx_ready is 0 from that cycle until the stop bit's last cycle completes.
//  RX path:
//   - uart_rxd passes through a 2-flop synchroniser; all sampling uses the synchronised value.
//   - IDLE: falling edge -> START.
//   - START: sample at CLK_DIV/2. If high (glitch) -> IDLE; otherwise -> DATA.
//   - DATA: 8 samples, each CLK_DIV apart, at bit centres, LSB first.
//   - STOP: sample the stop bit. If 1, push the byte. If 0, set frame_err and discard the byte. Then -> IDLE.
//  FIFO:
//   - Push when full: discard the new byte and set overrun (sticky).
//   - Push and pop in the same cycle: both take effect; count is unchanged.
//   - Pointers wrap modulo RX_FIFO_DEPTH.
//  en=0:
//   - TX and RX FSMs are forced to IDLE immediately, aborting any frame mid-operation.
//   - uart_txd=1 and the FIFO is flushed.
//   - Flags are kept; bus accesses still complete.
//  Reset asserted mid-frame returns every state to the reset values within the same edge.
// TESTING (sim with CLK_DIV=4, RX_FIFO_DEPTH=4)
//  1. Reset, then read STATUS -> 0x0. Write CTRL=1, read STATUS -> 0x2. Each access: bus_ready high exactly 1 cycle after accept.
//  2. Write DATA=0xA5 -> uart_txd 0,1,0,1,0,0,1,0,1,1, each 4 cycles. STATUS=0x1 during the frame; 0x2 after 40 cycles.
//  3. Drive a 0x3C frame on uart_rxd -> STATUS bit2=1. Read DATA -> 0x3C. A second read of DATA -> 0x0 with STATUS bit2=0.
//  4. Receive 5 bytes 0x01..0x05 with no reads -> STATUS bit3=1. Reads return 0x01..0x04, then 0. Write STATUS=0x8 -> bit3=0.
//  5. RX frame with stop bit 0 -> frame_err=1, FIFO empty. 2-cycle low glitch on uart_rxd -> no byte, no flag.
//  6. Start TX of 0xFF, clear CTRL.en mid-frame -> uart_txd=1 next cycle. Write DATA while en=0 -> no frame. Assert rst mid RX -> all outputs at reset values.

Source files
------------

// File: rtl/uart_mmio_slave.sv
// uart_mmio_slave: memory-mapped UART responder for the core data bus.
// Register map (byte offsets, only bus_addr[3:2] decoded):
//   0x0 DATA   read pops RX FIFO head, write starts a TX frame
//   0x4 STATUS {frame_err, overrun, rx_valid, tx_ready, tx_busy}
//   0x8 CTRL   bit0 en
//   0xC reserved, reads 0
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus_valid/we    request strobe (held until bus_ready) and direction
//   bus_addr/wdata  byte offset and store data
//   bus_rdata/ready registered load data and one-cycle completion pulse
//   uart_rxd        asynchronous serial input
//   uart_txd        serial output, idles high
module uart_mmio_slave #(
    parameter int unsigned CLK_DIV       = 868,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(RX_FIFO_DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Control / status registers
    logic en;
    logic overrun;
    logic frame_err;

    // TX state
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit_idx;
    logic [7:0]       tx_shift;

    // RX state
    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_idx;
    logic [7:0]       rx_shift;
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;

    // RX FIFO
    logic [7:0]       fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;

    // Decode of the current bus request
    logic        accept_c;
    logic [1:0]  sel_c;
    logic        data_wr_c;
    logic        data_rd_c;
    logic        status_wr_c;
    logic        ctrl_wr_c;
    logic        en_next_c;
    logic        fifo_empty_c;
    logic        fifo_full_c;
    logic        pop_c;
    logic        tx_idle_c;
    logic        tx_ready_c;
    logic        tx_start_c;
    logic        rx_done_c;
    logic        push_c;
    logic        push_ok_c;
    logic        overrun_set_c;
    logic        frame_err_set_c;
    logic [31:0] rdata_c;
    logic        unused_bits;

    assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

    assign accept_c    = bus_valid & ~bus_ready;
    assign sel_c       = bus_addr[3:2];
    assign data_wr_c   = accept_c &  bus_we & (sel_c == REG_DATA);
    assign data_rd_c   = accept_c & ~bus_we & (sel_c == REG_DATA);
    assign status_wr_c = accept_c &  bus_we & (sel_c == REG_STATUS);
    assign ctrl_wr_c   = accept_c &  bus_we & (sel_c == REG_CTRL);

    // Look-ahead enable so a CTRL write that clears en aborts frames on the same edge
    assign en_next_c = ctrl_wr_c ? bus_wdata[0] : en;

    assign fifo_empty_c = (level == '0);
    assign fifo_full_c  = (level == LVL_FULL);
    assign pop_c        = data_rd_c & ~fifo_empty_c;

    assign tx_idle_c  = (tx_state == TX_IDLE);
    assign tx_ready_c = en & tx_idle_c;
    assign tx_start_c = data_wr_c & tx_ready_c;

    // Stop-bit sample point decides push versus framing error
    assign rx_done_c       = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST);
    assign push_c          = rx_done_c &  rxd_sync & en_next_c;
    assign frame_err_set_c = rx_done_c & ~rxd_sync & en_next_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok_c       = push_c & (~fifo_full_c | pop_c);
    assign overrun_set_c   = push_c & fifo_full_c & ~pop_c;

    // Load data mux
    always_comb begin
        rdata_c = '0;
        case (sel_c)
            REG_DATA:   rdata_c = fifo_empty_c ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
            REG_STATUS: rdata_c = {27'd0, frame_err, overrun, ~fifo_empty_c,
                                   tx_ready_c, ~tx_idle_c};
            REG_CTRL:   rdata_c = {31'd0, en};
            default:    rdata_c = '0;
        endcase
    end

    // Bus response and control/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ready <= 1'b0;
            bus_rdata <= '0;
            en        <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            bus_ready <= accept_c;
            bus_rdata <= (accept_c & ~bus_we) ? rdata_c : 32'd0;
            en        <= en_next_c;
            // A new error event wins over a simultaneous software clear
            overrun   <= overrun_set_c |
                         (overrun & ~(status_wr_c & bus_wdata[3]));
            frame_err <= frame_err_set_c |
                         (frame_err & ~(status_wr_c & bus_wdata[4]));
        end
    end

    // RX FIFO pointers and fill level; disabling the UART flushes it
    always_ff @(posedge clk) begin
        if (rst || !en_next_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + LVL_W'(push_ok_c) - LVL_W'(pop_c);
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    // TX serialiser: start, 8 data bits LSB first, stop
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            uart_txd   <= 1'b1;
        end else if (!en_next_c) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            uart_txd   <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_start_c) begin
                        tx_state   <= TX_START;
                        tx_cnt     <= '0;
                        tx_bit_idx <= '0;
                        tx_shift   <= bus_wdata[7:0];
                        uart_txd   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                            uart_txd   <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= TX_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus edge history for the asynchronous RX pin
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // RX deserialiser: half-bit start qualification, then bit-centre sampling
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
        end else if (!en_next_c) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt     <= '0;
                        rx_bit_idx <= '0;
                        // Line back high at mid start bit means a glitch
                        rx_state   <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        if (rx_bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit_idx <= rx_bit_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_state <= RX_IDLE;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_slave.sv
// Self-checking bench for uart_mmio_slave with CLK_DIV=4, RX_FIFO_DEPTH=4.
// Load results are predicted from a small UART model and queued when the
// request is driven; they are popped and compared when bus_ready arrives.
module tb_uart_mmio_slave;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 4;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_RSVD   = 4'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = 4'h0;
    logic [31:0] bus_wdata = 32'h0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic last_txd = 1'b1;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        tx_q[$];

    // Reference model of the receive side and control state
    logic [7:0] m_rx[$];
    logic       m_en = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    uart_mmio_slave #(.CLK_DIV(CLK_DIV), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .uart_rxd  (uart_rxd),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input logic busy);
        return {27'd0, m_ferr, m_ovr, (m_rx.size() != 0), m_en & ~busy, busy};
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; returns 1 ns after the cycle following bus_ready
    task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wdata);
        int n;
        logic [31:0] exp;
        string tag;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_ready && n < 8);
        check_eq("ready_pulse", 32'(bus_ready), 32'd1);
        acc_cyc  = cyc;
        last_txd = uart_txd;
        if (!we) begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            check_eq(tag, bus_rdata, exp);
        end else begin
            check_eq("store_rdata", bus_rdata, 32'd0);
        end
        bus_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_drop", 32'(bus_ready), 32'd0);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_op(1'b0, addr, 32'd0);
    endtask

    task automatic rd_data(input string tag);
        logic [31:0] exp;
        exp = (m_rx.size() != 0) ? {24'd0, m_rx.pop_front()} : 32'd0;
        rd(A_DATA, exp, tag);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        if (addr == A_CTRL) begin
            m_en = data[0];
            if (!m_en) m_rx.delete();
        end
        if (addr == A_STATUS) begin
            if (data[3]) m_ovr = 1'b0;
            if (data[4]) m_ferr = 1'b0;
        end
        bus_op(1'b1, addr, data);
    endtask

    // Drive one serial frame on uart_rxd and update the model
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (6) @(negedge clk);
        if (m_en) begin
            if (!stop) m_ferr = 1'b1;
            else if (m_rx.size() < DEPTH) m_rx.push_back(b);
            else m_ovr = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        logic [7:0] txb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(bus_ready), 32'd0);
        check_eq("rst_rdata", bus_rdata, 32'd0);
        check_eq("rst_txd", 32'(uart_txd), 32'd1);

        // Register access basics
        rd(A_STATUS, exp_status(1'b0), "status_after_reset");
        wr(A_CTRL, 32'd1);
        rd(A_STATUS, exp_status(1'b0), "status_enabled");
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd(A_RSVD, 32'd0, "reserved_read");
        wr(A_CTRL, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'd1, "ctrl_upper_zero");

        // TX frame 0xA5 bit by bit, sampled mid-bit
        txb = 8'hA5;
        wr(A_DATA, {24'd0, txb});
        a = acc_cyc;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(txb[i]);
        tx_q.push_back(1'b1);
        for (int k = 0; k < 10; k++) begin
            wait_cyc(a + 4 * k + 2);
            check_eq("tx_bit", 32'(uart_txd), 32'(tx_q.pop_front()));
        end
        wait_cyc(a + 39);
        rd(A_STATUS, exp_status(1'b1), "status_last_stop_cycle");
        rd(A_STATUS, exp_status(1'b0), "status_tx_done");

        // Busy flag seen right after a write, dropped writes while busy
        wr(A_DATA, 32'h5A);
        a = acc_cyc;
        rd(A_STATUS, exp_status(1'b1), "status_tx_busy");
        wr(A_DATA, 32'h11);
        wait_cyc(a + 45);
        rd(A_STATUS, exp_status(1'b0), "status_tx_idle_again");

        // Single receive, then empty read
        send_frame(8'h3C, 1'b1);
        rd(A_STATUS, exp_status(1'b0), "status_rx_valid");
        rd_data("rx_3c");
        rd_data("rx_empty");
        rd(A_STATUS, exp_status(1'b0), "status_rx_drained");

        // Overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd(A_STATUS, exp_status(1'b0), "status_overrun");
        for (int i = 0; i < 5; i++) rd_data("rx_fifo_order");
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, exp_status(1'b0), "status_overrun_cleared");

        // Short glitch is rejected, bad stop bit flags frame error
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (2) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (12) @(negedge clk);
        rd(A_STATUS, exp_status(1'b0), "status_after_glitch");
        send_frame(8'h55, 1'b0);
        rd(A_STATUS, exp_status(1'b0), "status_frame_err");
        rd_data("rx_after_frame_err");
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, exp_status(1'b0), "status_frame_err_cleared");

        // Disabling flushes the FIFO
        send_frame(8'h77, 1'b1);
        wr(A_CTRL, 32'd0);
        wr(A_CTRL, 32'd1);
        rd_data("rx_flushed");

        // Abort TX during the start bit by clearing en
        wr(A_DATA, 32'hFF);
        wr(A_CTRL, 32'd0);
        check_eq("txd_abort_next_cycle", 32'(last_txd), 32'd1);
        rd(A_STATUS, exp_status(1'b0), "status_disabled");
        wr(A_DATA, 32'h00);
        for (int k = 0; k < 4; k++) begin
            repeat (2) @(posedge clk);
            #1;
            check_eq("txd_idle_disabled", 32'(uart_txd), 32'd1);
        end
        rd(A_STATUS, exp_status(1'b0), "status_no_frame_disabled");
        wr(A_CTRL, 32'd1);
        rd(A_STATUS, exp_status(1'b0), "status_reenabled");

        // Reset in the middle of both a TX and an RX frame
        wr(A_DATA, 32'h00);
        a = acc_cyc;
        @(negedge clk);
        uart_rxd = 1'b0;
        wait_cyc(a + 8);
        check_eq("txd_mid_frame", 32'(uart_txd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_mid_ready", 32'(bus_ready), 32'd0);
        check_eq("rst_mid_rdata", bus_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        uart_rxd = 1'b1;
        m_rx.delete();
        m_en = 1'b0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        rd(A_STATUS, exp_status(1'b0), "status_after_mid_reset");
        rd(A_CTRL, 32'd0, "ctrl_after_mid_reset");
        wr(A_CTRL, 32'd1);
        repeat (50) @(negedge clk);
        rd(A_STATUS, exp_status(1'b0), "status_clean_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
